// File: rtl/ps2_uart_tx.sv
// Buffered 8N1 UART transmitter: keyboard bytes enter a small FIFO over valid/ready
// and are serialized LSB first onto tx at CLK_HZ / BAUD cycles per bit.
module ps2_uart_tx #(
    parameter int unsigned CLK_HZ = 24000000,
    parameter int unsigned BAUD   = 9600,
    parameter int unsigned DEPTH  = 4
) (
    input  logic       clk,
    input  logic       clr_n,
    input  logic [7:0] data,
    input  logic       valid,
    output logic       ready,
    output logic       tx,
    output logic       busy
);

    localparam int unsigned DIV = CLK_HZ / BAUD;
    localparam int unsigned BW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned PW  = $clog2(DEPTH);
    localparam int unsigned CW  = $clog2(DEPTH + 1);

    localparam logic [BW-1:0] BaudLast  = BW'(DIV - 1);
    localparam logic [CW-1:0] CountFull = CW'(DEPTH);

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StData,
        StStop
    } state_e;

    state_e          state_q;
    logic [BW-1:0]   baud_q;
    logic [2:0]      bit_q;
    logic [7:0]      shift_q;

    logic [7:0]      mem_q [DEPTH];
    logic [PW-1:0]   wr_ptr_q;
    logic [PW-1:0]   rd_ptr_q;
    logic [CW-1:0]   count_q;
    logic [CW-1:0]   count_d;

    logic            push;
    logic            pop;
    logic            empty;
    logic            baud_last;
    logic [7:0]      head;

    assign ready     = (count_q != CountFull);
    assign empty     = (count_q == '0);
    assign push      = valid && ready;
    assign baud_last = (baud_q == BaudLast);
    assign head      = mem_q[rd_ptr_q];

    // The serializer takes the head either from IDLE or on the final STOP cycle,
    // which is what makes back-to-back frames gapless.
    assign pop = !empty && ((state_q == StIdle) || ((state_q == StStop) && baud_last));

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (!push && pop) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= data;
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q <= StIdle;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx      <= 1'b1;
            busy    <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    tx   <= 1'b1;
                    busy <= (count_d != '0);
                    if (pop) begin
                        shift_q <= head;
                        baud_q  <= '0;
                        state_q <= StStart;
                        tx      <= 1'b0;
                        busy    <= 1'b1;
                    end
                end
                StStart: begin
                    if (baud_last) begin
                        baud_q  <= '0;
                        bit_q   <= '0;
                        state_q <= StData;
                        tx      <= shift_q[0];
                    end else begin
                        baud_q <= baud_q + BW'(1);
                    end
                end
                StData: begin
                    if (baud_last) begin
                        baud_q <= '0;
                        if (bit_q == 3'd7) begin
                            state_q <= StStop;
                            tx      <= 1'b1;
                        end else begin
                            bit_q   <= bit_q + 3'd1;
                            shift_q <= {1'b0, shift_q[7:1]};
                            tx      <= shift_q[1];
                        end
                    end else begin
                        baud_q <= baud_q + BW'(1);
                    end
                end
                StStop: begin
                    if (baud_last) begin
                        baud_q <= '0;
                        if (pop) begin
                            shift_q <= head;
                            state_q <= StStart;
                            tx      <= 1'b0;
                        end else begin
                            state_q <= StIdle;
                            tx      <= 1'b1;
                            busy    <= (count_d != '0);
                        end
                    end else begin
                        baud_q <= baud_q + BW'(1);
                    end
                end
                default: begin
                    state_q <= StIdle;
                    tx      <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: doc/ps2_uart_tx.md
# ps2_uart_tx

Buffered 8N1 UART transmitter that consumes the ASCII byte stream from the PS/2 keyboard decoder and sends it to the host serial line. It sits directly downstream of the keyboard block. It accepts bytes over a valid/ready handshake into a small FIFO and serializes them onto `tx` at a fixed baud rate derived from the system clock.

## Interface
- `CLK_HZ`, default 24000000: system clock frequency in Hz.
- `BAUD`, default 9600: line rate. `DIV = CLK_HZ / BAUD` (integer, truncated), must be ≥ 2.
- `DEPTH`, default 4: FIFO entries, power of two, ≥ 2.

- `clk`  in  1  system clock; single clock domain, all state on rising edge.
- `clr_n`  in  1  asynchronous, active-low reset.
- `data`  in  8  byte from keyboard decoder.
- `valid`  in  1  `data` is valid.
- `ready`  out  1  FIFO can accept; combinational, `ready = (count != DEPTH)`.
- `tx`  out  1  serial output, idle high, registered.
- `busy`  out  1  high when the FIFO is non-empty or the serializer is not in IDLE; registered.

## Operation
- A push occurs on any edge with `valid && ready`. The byte is written at `wr_ptr`, `wr_ptr` increments, and the pointer wraps mod DEPTH. `count` is DEPTH+1 values wide.
- When `ready` is low, `data`/`valid` are ignored and the upstream must hold. No push is accepted while full, even on a cycle that pops.
- A simultaneous push and pop leaves `count` unchanged, and both pointers advance.
- Serializer FSM uses a baud counter (0..DIV-1) and a 3-bit bit index.
  - IDLE: `tx`=1. If FIFO non-empty, pop the head into the shift register, reset the baud counter, and go to START.
  - START: `tx`=0 for DIV cycles, then go to DATA with bit index 0.
  - DATA: `tx`=shift[0] for DIV cycles per bit, LSB first. Shift right after each bit. After bit 7, go to STOP.
  - STOP: `tx`=1 for DIV cycles. On the last cycle, if the FIFO is non-empty, pop and go directly to START (back-to-back, no idle gap). Otherwise go to IDLE.
- No parity, one stop bit; a frame is exactly 10·DIV cycles.
- Reset (asynchronous, any time, including mid-frame):
  - FIFO is emptied and pointers and count are cleared.
  - FSM goes to IDLE.
  - `tx`=1 and `busy`=0 immediately.
  - Any partial frame is truncated.
  - `ready`=1 while in and after reset; pushes during reset are discarded.

## Timing
- Push at edge N into an empty FIFO while IDLE:
  - Pop and start bit occur at edge N+1, so `tx` falls after edge N+1.
  - Start bit spans edges N+1..N+1+DIV.
  - Stop bit ends at edge N+1+10·DIV.
- `busy` rises the edge after the first push. It falls on the edge where STOP exits to IDLE with the FIFO empty.
- `ready` falls combinationally once `count` reaches DEPTH. It rises after the edge that pops while full.
- Throughput: one byte per 10·DIV cycles; the FIFO absorbs bursts of up to DEPTH+1 bytes (DEPTH queued plus one in the shifter).

## Test plan
- Use DIV=4 (`CLK_HZ`=4, `BAUD`=1) and DEPTH=4 for all scenarios.
- Single byte: push 0x41 at edge 0.
  - `tx` sampled each 4 cycles from edge 1 reads 0,1,0,0,0,0,0,1,0,1.
  - `tx` then stays 1; `busy` is low after edge 41.
- Back-to-back: push 0x55 then 0xAA on consecutive cycles.
  - Second start bit begins exactly at edge 41.
  - `tx` shows no idle cycles between frames; total 80 cycles.
- Full/stall: assert `valid` continuously with bytes A..F from edge 0.
  - A–E are accepted at edges 0–4.
  - `ready`=0 after edge 4, with F held.
  - B is popped at edge 41; F is accepted at edge 42.
  - All six bytes are transmitted in order.
- Handshake hold: drive `valid` with `ready`=0 and change `data` mid-stall (protocol violation). Only the value present on the accepting edge is transmitted.
- Reset mid-frame: drop `clr_n` during DATA bit 3 of 0x41 with 2 bytes queued.
  - `tx`=1, `busy`=0, `ready`=1 asynchronously.
  - After release, no further frames are sent until a new push occurs.
- Wrap-around: stream 12 bytes 0x00..0x0B with stalls.
  - Received sequence is identical, which checks pointer wrap across 3 FIFO cycles.
